assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_way.sv | 73 +++++++
 rtl/assoc_cache.sv | 214 +++++++++++++++++++++
 tb/tb_assoc_cache.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache: FSM states,
// access-size encodings and the byte-lane enable helper.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    INS_WORD = 2'd0,
    INS_HALF = 2'd1,
    INS_BYTE = 2'd2,
    INS_RSVD = 2'd3
  } ins_e;

  function automatic logic [3:0] byte_en(
    input logic [1:0] ins,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      ins == INS_WORD: be = 4'b1111;
      ins == INS_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      ins == INS_BYTE: be = 4'b0001 << a;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid/dirty/tag/data per set,
// combinational read at idx, fill / byte write / dirty clear.
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WORDS = 4,
  parameter int TB    = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  idx,
  input  logic [$clog2(WORDS)-1:0] wr_word,
  input  logic                     wr_en,
  input  logic [3:0]               wr_be,
  input  logic [31:0]              wr_data,
  input  logic                     fill_en,
  input  logic [TB-1:0]            fill_tag,
  input  logic [32*WORDS-1:0]      fill_line,
  input  logic                     clr_en,
  output logic                     valid,
  output logic                     dirty,
  output logic [TB-1:0]            tag,
  output logic [32*WORDS-1:0]      line
);

  logic [SETS-1:0]       valid_q, valid_d;
  logic [SETS-1:0]       dirty_q, dirty_d;
  logic [TB-1:0]         tag_q  [SETS];
  logic [32*WORDS-1:0]   data_q [SETS];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (wr_en) begin
      dirty_d[idx] = 1'b1;
    end else if (clr_en) begin
      dirty_d[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          data_q[idx][wr_word*32+b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];

endmodule

// File: rtl/assoc_cache.sv
// Write-back set-associative cache with LRU replacement.
// Define ASSOC_CACHE_STATS_EN to add Hit_Cnt / Miss_Cnt ports.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int WORDS = 4,
  localparam int OB = $clog2(WORDS*4),
  localparam int IB = $clog2(SETS),
  localparam int TB = 32 - IB - OB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Req_CPU,
  input  logic                Wr_CPU,
  input  logic [31:0]         A_CPU,
  input  logic [31:0]         DI_CPU,
  input  logic [1:0]          Ins_Type,
  output logic                Rdy_CPU,
  output logic [31:0]         DO_CPU,
  output logic                Req_Low,
  output logic                Wr_Low,
  output logic [31-OB:0]      A_Low,
  output logic [32*WORDS-1:0] DO_Low,
  input  logic [32*WORDS-1:0] DI_Low,
  input  logic                Rdy_Low
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]         Hit_Cnt,
  output logic [31:0]         Miss_Cnt
`endif
);

  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TB-1:0]        cpu_tag;
  logic [IB-1:0]        cpu_idx;
  logic [OB-3:0]        cpu_word;

  assign cpu_tag  = A_CPU[31:IB+OB];
  assign cpu_idx  = A_CPU[IB+OB-1:OB];
  assign cpu_word = A_CPU[OB-1:2];

  state_e               state_q, state_d;
  logic [AW-1:0]        vic_q, vic_d;
  logic [TB-1:0]        tag_q, tag_d;
  logic [IB-1:0]        idx_q, idx_d;
  logic [AW-1:0]        age_q [WAYS][SETS];
  logic [AW-1:0]        age_d [WAYS][SETS];

  logic [WAYS-1:0]      w_valid, w_dirty;
  logic [TB-1:0]        w_tag  [WAYS];
  logic [32*WORDS-1:0]  w_line [WAYS];
  logic [IB-1:0]        rd_idx;

  logic                 hit, miss, wr_hit;
  logic [AW-1:0]        hit_way, vic;
  logic                 found;
  logic [3:0]           be;

  // During a transfer the way ports follow the latched index.
  assign rd_idx = (state_q == IDLE) ? cpu_idx : idx_q;
  assign be     = byte_en(Ins_Type, A_CPU[1:0]);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && w_valid[w] && w_tag[w] == cpu_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  always_comb begin
    vic   = '0;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !w_valid[w]) begin
        vic   = AW'(w);
        found = 1'b1;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (!found && age_q[w][cpu_idx] == AW'(WAYS-1))
        vic = AW'(w);
    end
  end

  assign Rdy_CPU = (state_q == IDLE) && Req_CPU && hit;
  assign miss    = (state_q == IDLE) && Req_CPU && !hit;
  assign wr_hit  = Rdy_CPU && Wr_CPU && (Ins_Type != INS_RSVD);

  always_comb begin
    age_d = age_q;
    if (Rdy_CPU) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == hit_way)
          age_d[w][cpu_idx] = '0;
        else if (age_q[w][cpu_idx] < age_q[hit_way][cpu_idx])
          age_d[w][cpu_idx] = age_q[w][cpu_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vic_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          age_q[w][s] <= AW'(w);
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      age_q   <= age_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vic_d   = vic_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          vic_d   = vic;
          tag_d   = cpu_tag;
          idx_d   = cpu_idx;
          state_d = (w_valid[vic] && w_dirty[vic]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: if (Rdy_Low) state_d = REFILL;
      REFILL:    if (Rdy_Low) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    Req_Low = 1'b0;
    Wr_Low  = 1'b0;
    A_Low   = '0;
    DO_Low  = '0;
    DO_CPU  = Rdy_CPU ? w_line[hit_way][cpu_word*32 +: 32] : 32'd0;
    unique case (state_q)
      WRITEBACK: begin
        Req_Low = 1'b1;
        Wr_Low  = 1'b1;
        A_Low   = {w_tag[vic_q], idx_q};
        DO_Low  = w_line[vic_q];
      end
      REFILL: begin
        Req_Low = 1'b1;
        A_Low   = {tag_q, idx_q};
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(
      .SETS (SETS),
      .WORDS(WORDS),
      .TB   (TB)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .idx      (rd_idx),
      .wr_word  (cpu_word),
      .wr_en    (wr_hit && hit_way == AW'(g)),
      .wr_be    (be),
      .wr_data  (DI_CPU),
      .fill_en  (state_q == REFILL && Rdy_Low && vic_q == AW'(g)),
      .fill_tag (tag_q),
      .fill_line(DI_Low),
      .clr_en   (state_q == WRITEBACK && Rdy_Low && vic_q == AW'(g)),
      .valid    (w_valid[g]),
      .dirty    (w_dirty[g]),
      .tag      (w_tag[g]),
      .line     (w_line[g])
    );
  end

`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, Rdy_CPU};
    miss_cnt_d = miss_cnt_q + {31'd0, miss};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign Hit_Cnt  = hit_cnt_q;
  assign Miss_Cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Randomized scoreboard bench for assoc_cache (2 ways, 64 sets,
// 4 words) against an LRU-list reference model.
module tb_assoc_cache;

  localparam int WAYS  = 2;
  localparam int SETS  = 64;
  localparam int WORDS = 4;
  localparam int OB    = 4;
  localparam int IB    = 6;
  localparam int AL    = 32 - OB;

  typedef logic [32*WORDS-1:0] line_t;
  typedef struct {
    bit            wr;
    logic [AL-1:0] addr;
    line_t         data;
  } low_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Req_CPU = 1'b0;
  logic          Wr_CPU = 1'b0;
  logic [31:0]   A_CPU = '0;
  logic [31:0]   DI_CPU = '0;
  logic [1:0]    Ins_Type = '0;
  logic          Rdy_CPU;
  logic [31:0]   DO_CPU;
  logic          Req_Low;
  logic          Wr_Low;
  logic [AL-1:0] A_Low;
  line_t         DO_Low;
  line_t         DI_Low = '0;
  logic          Rdy_Low;
  logic          rdy_resp = 1'b0;
  logic          rdy_dir = 1'b0;
  bit            mem_pause = 1'b0;

  assign Rdy_Low = rdy_resp | rdy_dir;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_cpu [$];
  low_t        exp_low [$];

  int    lru [SETS][$];
  line_t cdata [int];
  bit    cdirty [int];
  line_t mem [int];

  assoc_cache #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .Req_CPU (Req_CPU),
    .Wr_CPU  (Wr_CPU),
    .A_CPU   (A_CPU),
    .DI_CPU  (DI_CPU),
    .Ins_Type(Ins_Type),
    .Rdy_CPU (Rdy_CPU),
    .DO_CPU  (DO_CPU),
    .Req_Low (Req_Low),
    .Wr_Low  (Wr_Low),
    .A_Low   (A_Low),
    .DO_Low  (DO_Low),
    .DI_Low  (DI_Low),
    .Rdy_Low (Rdy_Low)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, line_t act, line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < WORDS; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) lru[s].delete();
    cdata.delete();
    cdirty.delete();
  endfunction

  // Reference: each set is a recency list of resident tags (MRU first).
  task automatic model(input bit wr, input logic [31:0] a,
                       input logic [31:0] di, input logic [1:0] ins);
    int    la, st, tg, w, pos, vt, vla;
    line_t l;
    low_t  e;
    logic [3:0] be;
    la  = int'(a >> OB);
    st  = la % SETS;
    tg  = la / SETS;
    w   = int'(a[OB-1:2]);
    pos = -1;
    foreach (lru[st][i]) if (lru[st][i] == tg) pos = i;
    if (pos < 0) begin
      if (lru[st].size() == WAYS) begin
        vt  = lru[st].pop_back();
        vla = vt * SETS + st;
        if (cdirty[vla]) begin
          e.wr = 1; e.addr = AL'(vla); e.data = cdata[vla];
          exp_low.push_back(e);
          mem[vla] = cdata[vla];
        end
        cdata.delete(vla);
        cdirty.delete(vla);
      end
      if (!mem.exists(la)) mem[la] = rand_line();
      e.wr = 0; e.addr = AL'(la); e.data = mem[la];
      exp_low.push_back(e);
      cdata[la]  = mem[la];
      cdirty[la] = 0;
    end else begin
      lru[st].delete(pos);
    end
    lru[st].push_front(tg);
    l = cdata[la];
    exp_cpu.push_back(l[w*32 +: 32]);
    case (ins)
      2'd0:    be = 4'hF;
      2'd1:    be = a[1] ? 4'hC : 4'h3;
      2'd2:    be = 4'(1 << a[1:0]);
      default: be = 4'h0;
    endcase
    if (wr && ins != 2'd3) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) l[w*32+b*8 +: 8] = di[b*8 +: 8];
      cdata[la]  = l;
      cdirty[la] = 1;
    end
  endtask

  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] di, input logic [1:0] ins);
    bit done;
    model(wr, a, di, ins);
    Wr_CPU = wr; A_CPU = a; DI_CPU = di; Ins_Type = ins;
    Req_CPU = 1'b1;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (Rdy_CPU) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: got no Rdy_CPU expected Rdy_CPU for %h", a);
    end
    @(posedge clk); #1;
    Req_CPU = 1'b0;
  endtask

  task automatic do_reset();
    Req_CPU = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  // CPU-side monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (Rdy_CPU) begin
        if (exp_cpu.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rdy: got %h expected none", DO_CPU);
        end else begin
          e = exp_cpu.pop_front();
          chk("do_cpu", line_t'(DO_CPU), line_t'(e));
        end
      end
    end
  end

  // Memory-side responder and transfer checker
  initial begin
    low_t e;
    forever begin
      @(negedge clk);
      if (Req_Low && !mem_pause) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (exp_low.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_low: got A_Low %h expected none", A_Low);
          DI_Low = '0;
        end else begin
          e = exp_low.pop_front();
          chk("wr_low", line_t'(Wr_Low), line_t'(e.wr));
          chk("a_low", line_t'(A_Low), line_t'(e.addr));
          if (e.wr) chk("do_low", DO_Low, e.data);
          else DI_Low = e.data;
        end
        rdy_resp = 1'b1;
        @(posedge clk); #1;
        rdy_resp = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [31:0] a;
    mem[1] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hA5A5_A5A5};
    rst = 1'b0;
    #2;
    chk("rst_rdy_cpu", line_t'(Rdy_CPU), '0);
    chk("rst_req_low", line_t'(Req_Low), '0);
    chk("rst_wr_low", line_t'(Wr_Low), '0);
    chk("rst_do_cpu", line_t'(DO_CPU), '0);
    chk("rst_a_low", line_t'(A_Low), '0);
    chk("rst_do_low", DO_Low, '0);
    do_reset();

    access(0, 32'h0000_0010, 32'h0, 2'd0);
    access(1, 32'h0000_0013, 32'hFFFF_FFFF, 2'd2);
    access(0, 32'h0000_0010, 32'h0, 2'd0);

    do_reset();
    access(0, 32'h0000_0400, 32'h0, 2'd0);
    access(0, 32'h0000_0800, 32'h0, 2'd0);
    access(0, 32'h0000_0400, 32'h0, 2'd0);
    access(1, 32'h0000_0804, 32'h1234_5678, 2'd0);
    access(0, 32'h0000_0C00, 32'h0, 2'd0);
    access(1, 32'h0000_0802, 32'hBEEF_0000, 2'd1);
    access(0, 32'h0000_0C08, 32'h0, 2'd0);
    access(0, 32'h0000_0400, 32'h0, 2'd0);

    // Abandoned miss, address change, then reset during refill.
    do_reset();
    mem_pause = 1'b1;
    A_CPU = 32'h0000_1230; Wr_CPU = 0; Ins_Type = 0; Req_CPU = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (Req_Low) seen = 1;
    end
    chk("abort_req_low", line_t'(seen), line_t'(1));
    chk("abort_a_low", line_t'(A_Low), line_t'(28'h000_0123));
    @(posedge clk); #1;
    Req_CPU = 1'b0;
    A_CPU = 32'h0000_5670;
    repeat (3) @(negedge clk);
    chk("abort_hold_req", line_t'(Req_Low), line_t'(1));
    chk("abort_hold_a", line_t'(A_Low), line_t'(28'h000_0123));
    rdy_dir = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_req_low", line_t'(Req_Low), '0);
    chk("rst_mid_wr_low", line_t'(Wr_Low), '0);
    rdy_dir = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    mem_pause = 1'b0;
    access(0, 32'h0000_1230, 32'h0, 2'd0);

    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      a = ($urandom_range(0, 3) << (IB + OB)) |
          ($urandom_range(0, 3) << OB) | ($urandom & 32'hF);
      access(bit'($urandom_range(0, 1)), a, $urandom,
             2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    chk("cpu_queue_empty", line_t'(exp_cpu.size()), '0);
    chk("low_queue_empty", line_t'(exp_low.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
